mod_dma: RTL and testbench

Single-channel word-copy DMA engine for the PLP bus. Software programs a source, destination and word count through a memory-mapped slave window. The engine then acts as a bus initiator, issuing alternating read and write cycles through its master port until the block is copied. It sits beside the CPU on the arbiter and raises a level interrupt when the copy completes.

---
 rtl/mod_dma.sv | 156 +++++++++++++++
 tb/tb_mod_dma.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_dma.sv
// Single-channel word-copy DMA for the PLP bus: a slave register window
// programs SRC/DST/CNT, and a master port alternates read/write cycles.
module mod_dma (
  input  logic        clk,
  input  logic        rst,
  input  logic        ie,
  input  logic        de,
  input  logic [31:0] iaddr,
  input  logic [31:0] daddr,
  input  logic [1:0]  drw,
  input  logic [31:0] din,
  output logic [31:0] iout,
  output logic [31:0] dout,
  output logic        m_req,
  input  logic        m_grant,
  output logic [31:0] m_addr,
  output logic [1:0]  m_drw,
  output logic [31:0] m_dout,
  input  logic [31:0] m_din,
  output logic        irq
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_e;

  state_e      state_q, state_d;
  logic [31:0] src_q, src_d;
  logic [31:0] dst_q, dst_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] data_q, data_d;
  logic        done_q, done_d;

  logic busy;
  logic wr_en;
  logic rd_en;
  logic unused_ok;

  assign busy      = (state_q != S_IDLE);
  assign wr_en     = de && (drw == 2'b01);
  assign rd_en     = de && (drw == 2'b10);
  assign unused_ok = ^{ie, iaddr};
  assign iout      = 32'd0;
  assign irq       = done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      src_q   <= 32'd0;
      dst_q   <= 32'd0;
      cnt_q   <= 32'd0;
      data_q  <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  // Master progress is computed first so that an ABORT in the same cycle
  // overrides the state change but keeps the address/count updates.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    done_d  = done_q;

    case (state_q)
      S_READ: begin
        if (m_grant) begin
          data_d  = m_din;
          src_d   = src_q + 32'd4;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (m_grant) begin
          dst_d = dst_q + 32'd4;
          cnt_d = cnt_q - 32'd1;
          if (cnt_q == 32'd1) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_READ;
          end
        end
      end
      default: ;
    endcase

    if (wr_en) begin
      if (busy) begin
        if ((daddr == 32'hC) && din[2]) begin
          state_d = S_IDLE;
          done_d  = 1'b0;
        end
      end else begin
        case (daddr)
          32'h0: src_d = din;
          32'h4: dst_d = din;
          32'h8: cnt_d = din;
          32'hC: begin
            if (din[0]) begin
              if (cnt_q == 32'd0) begin
                done_d = 1'b1;
              end else begin
                done_d  = 1'b0;
                state_d = S_READ;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    m_req  = 1'b0;
    m_drw  = 2'b00;
    m_addr = 32'd0;
    m_dout = 32'd0;
    case (state_q)
      S_READ: begin
        m_req  = 1'b1;
        m_drw  = 2'b10;
        m_addr = src_q;
      end
      S_WRITE: begin
        m_req  = 1'b1;
        m_drw  = 2'b01;
        m_addr = dst_q;
        m_dout = data_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    dout = 32'd0;
    if (rd_en) begin
      case (daddr)
        32'h0:   dout = src_q;
        32'h4:   dout = dst_q;
        32'h8:   dout = cnt_q;
        32'hC:   dout = {29'd0, 1'b0, done_q, busy};
        default: dout = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_dma.sv
// Scoreboard bench for mod_dma: each START pushes the expected bus cycles of
// the whole copy; a negedge monitor pops and compares every granted cycle.
`timescale 1ns/1ps
module tb_mod_dma;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ie = 1'b0;
  logic        de = 1'b0;
  logic [31:0] iaddr = 32'd0;
  logic [31:0] daddr = 32'd0;
  logic [1:0]  drw = 2'b00;
  logic [31:0] din = 32'd0;
  logic [31:0] iout;
  logic [31:0] dout;
  logic        m_req;
  logic        m_grant = 1'b0;
  logic [31:0] m_addr;
  logic [1:0]  m_drw;
  logic [31:0] m_dout;
  logic [31:0] m_din;
  logic        irq;

  int checks = 0;
  int errors = 0;
  int gmode = 0;             // 0 grant low, 1 grant high, 2 random grant
  logic [31:0] salt = 32'h1234_5678;

  typedef struct {
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] data;
  } xact_t;
  xact_t exp_q[$];

  mod_dma dut (
    .clk(clk), .rst(rst), .ie(ie), .de(de), .iaddr(iaddr), .daddr(daddr),
    .drw(drw), .din(din), .iout(iout), .dout(dout), .m_req(m_req),
    .m_grant(m_grant), .m_addr(m_addr), .m_drw(m_drw), .m_dout(m_dout),
    .m_din(m_din), .irq(irq)
  );

  always #5 clk = ~clk;

  // Memory contents as a pure function of address and a per-test salt.
  function automatic logic [31:0] mem_word(input logic [31:0] a, input logic [31:0] s);
    return (a * 32'h9E37_79B1) ^ s;
  endfunction

  assign m_din = mem_word(m_addr, salt);

  always @(posedge clk) begin
    #2;
    if (gmode == 2) m_grant = 1'($urandom_range(0, 1));
    else            m_grant = (gmode == 1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (m_req && m_grant) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_bus_cycle", m_addr, 32'hDEAD_DEAD);
        end else begin
          xact_t x;
          x = exp_q.pop_front();
          chk("bus_drw", {30'd0, m_drw}, x.is_wr ? 32'd1 : 32'd2);
          chk("bus_addr", m_addr, x.addr);
          if (x.is_wr) chk("bus_wdata", m_dout, x.data);
        end
      end else if (!m_req) begin
        chk("idle_outputs", {m_drw, 30'd0} | m_addr | m_dout, 32'd0);
      end
    end
  end

  task automatic push_copy(input logic [31:0] s, input logic [31:0] d, input int n);
    for (int k = 0; k < n; k++) begin
      logic [31:0] ra;
      logic [31:0] wa;
      ra = s + 32'(4 * k);
      wa = d + 32'(4 * k);
      exp_q.push_back('{1'b0, ra, 32'd0});
      exp_q.push_back('{1'b1, wa, mem_word(ra, salt)});
    end
  endtask

  // Caller sits just after a rising edge; returns just after the write edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] v);
    de = 1'b1; drw = 2'b01; daddr = a; din = v;
    @(posedge clk); #1;
    de = 1'b0; drw = 2'b00; daddr = 32'd0; din = 32'd0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    de = 1'b1; drw = 2'b10; daddr = a;
    #1 v = dout;
    de = 1'b0; drw = 2'b00; daddr = 32'd0;
  endtask

  task automatic chk_regs(input string nm, input logic [31:0] s, input logic [31:0] d,
                          input logic [31:0] c, input logic [31:0] st);
    logic [31:0] v;
    rd(32'h0, v); chk({nm, "_src"}, v, s);
    rd(32'h4, v); chk({nm, "_dst"}, v, d);
    rd(32'h8, v); chk({nm, "_cnt"}, v, c);
    rd(32'hC, v); chk({nm, "_stat"}, v, st);
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    while (!irq && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("done_within_budget", {31'd0, irq}, 32'd1);
  endtask

  task automatic start_copy(input logic [31:0] s, input logic [31:0] d, input int n);
    wr(32'h0, s);
    wr(32'h4, d);
    wr(32'h8, 32'(n));
    push_copy(s, d, n);
    wr(32'hC, 32'h1);
  endtask

  initial begin
    int cyc;
    logic [31:0] v;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_req", {31'd0, m_req}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_iout", iout, 32'd0);
    chk_regs("rst", 32'd0, 32'd0, 32'd0, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic copy with continuous grant
    gmode = 1;
    start_copy(32'h100, 32'h200, 3);
    chk("basic_req_after_start", {31'd0, m_req}, 32'd1);
    wait_done(50, cyc);
    chk("basic_cycles", 32'(cyc), 32'd6);
    chk("basic_queue_empty", 32'(exp_q.size()), 32'd0);
    chk_regs("basic", 32'h10C, 32'h20C, 32'd0, 32'h2);

    // Zero count, then ABORT in idle leaves DONE alone
    @(posedge clk); #1;
    wr(32'h8, 32'd0);
    wr(32'hC, 32'h1);
    chk("zero_irq", {31'd0, irq}, 32'd1);
    chk("zero_no_req", {31'd0, m_req}, 32'd0);
    rd(32'hC, v); chk("zero_stat", v, 32'h2);
    wr(32'hC, 32'h4);
    rd(32'hC, v); chk("idle_abort_stat", v, 32'h2);

    // Grant stall of 5 cycles in the first READ
    gmode = 0;
    salt = 32'hCAFE_0001;
    start_copy(32'h300, 32'h400, 2);
    for (int i = 0; i < 5; i++) begin
      chk("stall_addr", m_addr, 32'h300);
      chk("stall_drw", {30'd0, m_drw}, 32'd2);
      @(posedge clk); #1;
    end
    gmode = 1;
    wait_done(50, cyc);
    chk("stall_cycles", 32'(cyc + 5), 32'd9);
    chk_regs("stall", 32'h308, 32'h408, 32'd0, 32'h2);

    // Busy protection, then ABORT after one word
    gmode = 0;
    @(posedge clk); #1;
    start_copy(32'h500, 32'h600, 4);
    wr(32'h8, 32'd9);
    wr(32'hC, 32'h1);
    rd(32'h8, v); chk("busy_cnt_kept", v, 32'd4);
    rd(32'hC, v); chk("busy_stat", v, 32'h1);
    @(posedge clk); #1;
    gmode = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    gmode = 0;
    @(posedge clk); #1;
    wr(32'hC, 32'h5);
    chk("abort_queue_left", 32'(exp_q.size()), 32'd6);
    exp_q.delete();
    chk("abort_irq", {31'd0, irq}, 32'd0);
    chk_regs("abort", 32'h504, 32'h604, 32'd3, 32'd0);

    // Address wrap
    gmode = 1;
    salt = 32'h0BAD_F00D;
    start_copy(32'hFFFF_FFFC, 32'hFFFF_FFF8, 2);
    wait_done(50, cyc);
    chk("wrap_queue_empty", 32'(exp_q.size()), 32'd0);
    chk_regs("wrap", 32'h4, 32'h0, 32'd0, 32'h2);

    // Randomized copies with random grant
    for (int t = 0; t < 8; t++) begin
      logic [31:0] s;
      logic [31:0] d;
      int n;
      s = $urandom;
      d = $urandom;
      n = $urandom_range(1, 6);
      gmode = 2;
      @(posedge clk); #1;
      salt = $urandom;
      start_copy(s, d, n);
      rd(32'hC, v); chk("rand_busy_after_start", v, 32'h1);
      wait_done(400, cyc);
      chk("rand_queue_empty", 32'(exp_q.size()), 32'd0);
      chk_regs("rand", s + 32'(4 * n), d + 32'(4 * n), 32'd0, 32'h2);
    end

    // Asynchronous reset in the middle of a copy
    gmode = 1;
    @(posedge clk); #1;
    start_copy(32'h700, 32'h800, 5);
    @(posedge clk); #1;
    @(posedge clk); #1;
    #1 rst = 1'b1;
    #1;
    chk("midrst_m_req", {31'd0, m_req}, 32'd0);
    chk("midrst_irq", {31'd0, irq}, 32'd0);
    chk_regs("midrst", 32'd0, 32'd0, 32'd0, 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    gmode = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_idle", {31'd0, m_req}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
